regfile_scoreboard: RTL

- 32 x 32-bit integer register file plus per-register pending-write scoreboard; the responder side of the decode stage's register-read and hazard interface.
- Serves two combinational read ports to decode and accepts one write-back port.
- Tracks in-flight writers per destination register and raises stall_o when decode reads a register whose newest value is not yet written back.
- Replaces per-stage address compares in decode with a counter-based scoreboard.

---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode-side register-read, hazard, issue and write-back bundle.
// The decode stage is the master; the register file and scoreboard are the slave.
interface regfile_scoreboard_if;
  logic        reg1_read_i;
  logic [4:0]  reg1_addr_i;
  logic        reg2_read_i;
  logic [4:0]  reg2_addr_i;
  logic [31:0] reg1_data_o;
  logic [31:0] reg2_data_o;
  logic        stall_o;
  logic        issue_i;
  logic        issue_wreg_i;
  logic [4:0]  issue_wd_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        busy_any_o;
  logic        err_o;

  modport master (
    output reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i,
           issue_i, issue_wreg_i, issue_wd_i, wb_we_i, wb_addr_i, wb_data_i,
    input  reg1_data_o, reg2_data_o, stall_o, busy_any_o, err_o
  );

  modport slave (
    input  reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i,
           issue_i, issue_wreg_i, issue_wd_i, wb_we_i, wb_addr_i, wb_data_i,
    output reg1_data_o, reg2_data_o, stall_o, busy_any_o, err_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with write bypass and a per-register pending-writer
// counter scoreboard that flags RAW hazards to decode.
module regfile_scoreboard #(
  parameter int PEND_W = 2
) (
  input logic               clk,
  input logic               rst,
  regfile_scoreboard_if.slave rf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs_q [32];
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];
  logic              busy_any_q, busy_any_d;
  logic              err_q, err_d;
  logic              do_issue, do_wb;
  logic              haz1, haz2;

  assign do_issue = rf.issue_i && rf.issue_wreg_i && (rf.issue_wd_i != 5'd0);
  assign do_wb    = rf.wb_we_i && (rf.wb_addr_i != 5'd0);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_d     = pend_q;
    err_d      = err_q;
    busy_any_d = 1'b0;
    // An issue and a retire on the same register cancel out.
    if (!(do_issue && do_wb && rf.issue_wd_i == rf.wb_addr_i)) begin
      if (do_issue) begin
        if (pend_q[rf.issue_wd_i] == PEND_MAX) err_d = 1'b1;
        else pend_d[rf.issue_wd_i] = pend_q[rf.issue_wd_i] + PEND_ONE;
      end
      if (do_wb) begin
        if (pend_q[rf.wb_addr_i] == '0) err_d = 1'b1;
        else pend_d[rf.wb_addr_i] = pend_q[rf.wb_addr_i] - PEND_ONE;
      end
    end
    for (int i = 0; i < 32; i++) begin
      busy_any_d = busy_any_d | (pend_d[i] != '0);
    end
  end

  // NOTE: reset is synchronous and clears the whole array, so the register
  // storage cannot map onto a RAM macro; this is intentional for a 32-entry file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      busy_any_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (do_wb) regs_q[rf.wb_addr_i] <= rf.wb_data_i;
      pend_q     <= pend_d;
      busy_any_q <= busy_any_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    rf.reg1_data_o = 32'd0;
    if (rf.reg1_read_i && rf.reg1_addr_i != 5'd0) begin
      if (rf.wb_we_i && rf.wb_addr_i == rf.reg1_addr_i) rf.reg1_data_o = rf.wb_data_i;
      else rf.reg1_data_o = regs_q[rf.reg1_addr_i];
    end
  end

  always_comb begin
    rf.reg2_data_o = 32'd0;
    if (rf.reg2_read_i && rf.reg2_addr_i != 5'd0) begin
      if (rf.wb_we_i && rf.wb_addr_i == rf.reg2_addr_i) rf.reg2_data_o = rf.wb_data_i;
      else rf.reg2_data_o = regs_q[rf.reg2_addr_i];
    end
  end

  // A single outstanding writer retiring this cycle is covered by the bypass.
  assign haz1 = rf.reg1_read_i && (rf.reg1_addr_i != 5'd0) && (pend_q[rf.reg1_addr_i] != '0)
             && !(rf.wb_we_i && rf.wb_addr_i == rf.reg1_addr_i && pend_q[rf.reg1_addr_i] == PEND_ONE);
  assign haz2 = rf.reg2_read_i && (rf.reg2_addr_i != 5'd0) && (pend_q[rf.reg2_addr_i] != '0)
             && !(rf.wb_we_i && rf.wb_addr_i == rf.reg2_addr_i && pend_q[rf.reg2_addr_i] == PEND_ONE);

  assign rf.stall_o    = haz1 | haz2;
  assign rf.busy_any_o = busy_any_q;
  assign rf.err_o      = err_q;

endmodule
